// File: rtl/cap_frame_sched_pkg.sv
// cap_frame_sched_pkg: shared state encoding, minimum frame length and default widths.
// Rev 1.0
`default_nettype none

package cap_frame_sched_pkg;

  localparam int CAP_W_DEF = 14;
  localparam int FRM_W_DEF = 16;
  localparam int GAP_W_DEF = 24;
  localparam int TMO_W_DEF = 32;

  // The capture counter's last-point compare underflows below this.
  localparam int CAP_MIN_POINTS = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_CAPT = 3'd2,
    S_REL  = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cap_frame_sched_timer.sv
// cap_frame_sched_timer: loadable up/down counter with a compare-match flag.
// Rev 1.0
`default_nettype none

module cap_frame_sched_timer
  import cap_frame_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] cmp_val,
  output logic         hit
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? count + W'(1) : count - W'(1);
    end
  end

  assign hit = (count == cmp_val);

endmodule

`default_nettype wire

// File: rtl/cap_frame_sched.sv
// cap_frame_sched: arms, gates and repeats capture frames, reporting done/timeout/config status.
// Rev 1.0
`default_nettype none

module cap_frame_sched
  import cap_frame_sched_pkg::*;
#(
  parameter int CAP0_6 = CAP_W_DEF,
  parameter int FRM_W  = FRM_W_DEF,
  parameter int GAP_W  = GAP_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_trig_mode,
  input  logic [CAP0_6-1:0] cfg_cap_points,
  input  logic [FRM_W-1:0]  cfg_frames,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [TMO_W-1:0]  cfg_timeout,
  input  logic              trig,
  output logic [CAP0_6-1:0] cap_points,
  output logic              add_en,
  input  logic              add_cmpt,
  output logic              busy,
  output logic [FRM_W-1:0]  frame_idx,
  output logic              frame_start,
  output logic              done,
  output logic              tmo_err,
  output logic              cfg_err
);

  state_t             state;
  logic               trig_d;
  logic               trig_mode_q;
  logic [FRM_W-1:0]   frames_q;
  logic [GAP_W-1:0]   gap_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               gap_hit;
  logic               tmo_hit;

  wire                trig_rise   = trig & ~trig_d;
  // A frame count of zero runs a single frame.
  wire [FRM_W-1:0]    frames_last = (frames_q == '0) ? '0 : frames_q - FRM_W'(1);
  wire                tmo_fire    = (tmo_q != '0) && tmo_hit;

  cap_frame_sched_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_REL),
    .load_val (gap_q),
    .en       (state == S_GAP),
    .up       (1'b0),
    .cmp_val  (GAP_W'(1)),
    .hit      (gap_hit)
  );

  cap_frame_sched_timer #(.W(TMO_W)) u_tmo_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_ARM),
    .load_val ('0),
    .en       (state == S_CAPT),
    .up       (1'b1),
    .cmp_val  (tmo_q - TMO_W'(1)),
    .hit      (tmo_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_d <= 1'b0;
    else     trig_d <= trig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      trig_mode_q <= 1'b0;
      frames_q    <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      cap_points  <= '0;
      add_en      <= 1'b0;
      busy        <= 1'b0;
      frame_idx   <= '0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      tmo_err     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      done        <= 1'b0;
      if (cfg_abort) begin
        state  <= S_IDLE;
        add_en <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_start) begin
              if (cfg_cap_points < CAP0_6'(CAP_MIN_POINTS)) begin
                cfg_err <= 1'b1;
              end else begin
                trig_mode_q <= cfg_trig_mode;
                frames_q    <= cfg_frames;
                gap_q       <= cfg_gap;
                tmo_q       <= cfg_timeout;
                cap_points  <= cfg_cap_points;
                tmo_err     <= 1'b0;
                cfg_err     <= 1'b0;
                frame_idx   <= '0;
                busy        <= 1'b1;
                state       <= S_ARM;
              end
            end
          end
          S_ARM: begin
            if (!trig_mode_q || trig_rise) begin
              add_en      <= 1'b1;
              frame_start <= 1'b1;
              state       <= S_CAPT;
            end
          end
          S_CAPT: begin
            if (add_cmpt) begin
              add_en <= 1'b0;
              state  <= S_REL;
            end else if (tmo_fire) begin
              tmo_err <= 1'b1;
              add_en  <= 1'b0;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end
          end
          S_REL: begin
            if (frame_idx == frames_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              frame_idx <= frame_idx + FRM_W'(1);
              state     <= (gap_q == '0) ? S_ARM : S_GAP;
            end
          end
          S_GAP: begin
            if (gap_hit) state <= S_ARM;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cap_frame_sched.sv
// tb_cap_frame_sched: schedule-based reference model checked every cycle, plus directed literal checks.
// Rev 1.0
`default_nettype none

module tb_cap_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic        cfg_trig_mode = 1'b0;
  logic [13:0] cfg_cap_points = '0;
  logic [15:0] cfg_frames = '0;
  logic [23:0] cfg_gap = '0;
  logic [31:0] cfg_timeout = '0;
  logic        trig = 1'b0;
  logic [13:0] cap_points;
  logic        add_en;
  logic        add_cmpt;
  logic        busy;
  logic [15:0] frame_idx;
  logic        frame_start;
  logic        done;
  logic        tmo_err;
  logic        cfg_err;

  always #5 clk = ~clk;

  cap_frame_sched dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_abort      (cfg_abort),
    .cfg_trig_mode  (cfg_trig_mode),
    .cfg_cap_points (cfg_cap_points),
    .cfg_frames     (cfg_frames),
    .cfg_gap        (cfg_gap),
    .cfg_timeout    (cfg_timeout),
    .trig           (trig),
    .cap_points     (cap_points),
    .add_en         (add_en),
    .add_cmpt       (add_cmpt),
    .busy           (busy),
    .frame_idx      (frame_idx),
    .frame_start    (frame_start),
    .done           (done),
    .tmo_err        (tmo_err),
    .cfg_err        (cfg_err)
  );

  // Capture-counter stand-in: completes after cmpt_len cycles of add_en.
  logic [15:0] ccnt;
  bit          cmpt_on = 1'b1;
  bit          cmpt_force = 1'b0;
  int          cmpt_len = 16;

  always @(posedge clk or posedge rst) begin
    if (rst)         ccnt <= '0;
    else if (add_en) ccnt <= ccnt + 16'd1;
    else             ccnt <= '0;
  end

  assign add_cmpt = (cmpt_on && add_en && (int'(ccnt) >= cmpt_len - 1)) || cmpt_force;

  int n_chk = 0;
  int n_fail = 0;
  int tcyc = 0;

  // Reference model: tracks the run as a schedule of absolute cycle numbers.
  bit          m_busy, m_en, m_fs, m_done, m_tmo, m_cfg, m_mode, m_tp;
  logic [15:0] m_idx = '0;
  logic [13:0] m_pts = '0;
  int          m_frames, m_gap, en_start;
  int          arm_from = -1;
  int          done_at = -1;
  int          inc_at = -1;
  longint      m_lim;

  int n_fs, n_done, n_rise, low_cnt, low_last, hi_cnt, hi_last, t0, k;
  int rise_t [4];
  bit prev_en, busy_at_done;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  task automatic model_step();
    bit     e;
    int     fe;
    longint len;
    if (rst) begin
      m_busy = 0; m_en = 0; m_fs = 0; m_done = 0; m_tmo = 0; m_cfg = 0; m_mode = 0; m_tp = 0;
      m_idx = '0; m_pts = '0; arm_from = -1; done_at = -1; inc_at = -1;
      return;
    end
    e    = trig && !m_tp;
    m_tp = trig;
    m_fs = 0;
    if (cfg_abort) begin
      m_en = 0; m_busy = 0; m_done = 0;
      arm_from = -1; done_at = -1; inc_at = -1;
    end else if (!m_busy && !m_done) begin
      if (cfg_start) begin
        if (cfg_cap_points < 14'd2) begin
          m_cfg = 1;
        end else begin
          m_pts = cfg_cap_points; m_frames = int'(cfg_frames); m_gap = int'(cfg_gap);
          m_lim = longint'(cfg_timeout); m_mode = cfg_trig_mode;
          m_cfg = 0; m_tmo = 0; m_idx = '0; m_busy = 1;
          arm_from = tcyc + 1;
        end
      end
    end else begin
      m_done = 0;
      if (m_busy && m_en) begin
        fe  = (m_frames == 0) ? 1 : m_frames;
        len = longint'(tcyc - en_start);
        if (add_cmpt) begin
          m_en = 0;
          if (int'(m_idx) == fe - 1) begin
            done_at = tcyc + 2;
          end else begin
            inc_at   = tcyc + 2;
            arm_from = tcyc + 2 + m_gap;
          end
        end else if (m_lim != 0 && len == m_lim - 1) begin
          m_en = 0; m_busy = 0; m_tmo = 1;
        end
      end else if (m_busy) begin
        if (tcyc + 1 == done_at) begin m_done = 1; m_busy = 0; done_at = -1; end
        if (tcyc + 1 == inc_at) begin m_idx = m_idx + 16'd1; inc_at = -1; end
        if (arm_from >= 0 && tcyc >= arm_from && (!m_mode || e)) begin
          m_en = 1; m_fs = 1; en_start = tcyc + 1; arm_from = -1;
        end
      end
    end
  endtask

  task automatic clr_stats();
    n_fs = 0; n_done = 0; n_rise = 0; low_last = -1; hi_last = -1; busy_at_done = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
      tcyc++;
      chk("busy", busy, m_busy);
      chk("add_en", add_en, m_en);
      chk("frame_idx", frame_idx, m_idx);
      chk("frame_start", frame_start, m_fs);
      chk("done", done, m_done);
      chk("tmo_err", tmo_err, m_tmo);
      chk("cfg_err", cfg_err, m_cfg);
      chk("cap_points", cap_points, m_pts);
      n_fs += int'(frame_start);
      if (done) begin n_done++; busy_at_done = busy; end
      if (add_en) begin
        if (!prev_en) begin
          low_last = low_cnt;
          if (n_rise < 4) rise_t[n_rise] = tcyc;
          n_rise++;
          hi_cnt = 0;
        end
        hi_cnt++;
      end else begin
        if (prev_en) begin hi_last = hi_cnt; low_cnt = 0; end
        low_cnt++;
      end
      prev_en = add_en;
    end
  endtask

  task automatic cfg_set(input bit mode, input int pts, input int frames, input int gap, input longint tmo);
    cfg_trig_mode  = mode;
    cfg_cap_points = 14'(pts);
    cfg_frames     = 16'(frames);
    cfg_gap        = 24'(gap);
    cfg_timeout    = 32'(tmo);
    cmpt_len       = pts;
  endtask

  task automatic start_run(input bit mode, input int pts, input int frames, input int gap, input longint tmo);
    cfg_set(mode, pts, frames, gap, tmo);
    clr_stats();
    cfg_start = 1'b1;
    step(1);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int w = 0;
    while ((busy || m_busy || m_done) && w < budget) begin
      step(1);
      w++;
    end
    chk("wait_budget", longint'(w < budget), 1);
    step(3);
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_add_en", add_en, 0);
    chk("rst_frame_idx", frame_idx, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    step(2);

    // Free-run, 3 frames of 16 points with a 4-cycle gap.
    start_run(0, 16, 3, 4, 0);
    wait_done(400);
    chk("fr_frames", n_fs, 3);
    chk("fr_done", n_done, 1);
    chk("fr_low_time", low_last, 6);
    chk("fr_high_time", hi_last, 16);
    chk("fr_last_idx", frame_idx, 2);
    chk("fr_busy_at_done", busy_at_done, 0);

    // Trigger mode: edges in ARM at 10 and 50; edges during CAPT (14) and GAP (20) are dropped.
    cfg_set(1, 8, 2, 3, 0);
    clr_stats();
    t0 = tcyc;
    for (int r = 0; r < 71; r++) begin
      cfg_start = (r == 0);
      trig      = (r == 10 || r == 14 || r == 20 || r == 50);
      step(1);
    end
    cfg_start = 1'b0;
    trig      = 1'b0;
    wait_done(100);
    chk("trg_frames", n_fs, 2);
    chk("trg_rise0", rise_t[0] - t0, 11);
    chk("trg_rise1", rise_t[1] - t0, 51);
    chk("trg_done", n_done, 1);

    // Timeout with no completion, then a clean run clears the sticky flag.
    cmpt_on = 1'b0;
    start_run(0, 16, 1, 0, 20);
    wait_done(200);
    chk("tmo_high_time", hi_last, 20);
    chk("tmo_flag", tmo_err, 1);
    chk("tmo_no_done", n_done, 0);
    cmpt_on = 1'b1;
    start_run(0, 4, 1, 0, 0);
    wait_done(200);
    chk("tmo_cleared", tmo_err, 0);
    chk("tmo_rerun_done", n_done, 1);

    // Rejected start, then an accepted one with the minimum legal length.
    start_run(0, 1, 1, 0, 0);
    step(3);
    chk("cfg_flag", cfg_err, 1);
    chk("cfg_busy", busy, 0);
    chk("cfg_no_frame", n_fs, 0);
    start_run(0, 2, 1, 0, 0);
    wait_done(100);
    chk("cfg_cleared", cfg_err, 0);
    chk("cfg_min_done", n_done, 1);
    chk("cfg_min_high", hi_last, 2);

    // Abort in frame 1 of 4 coincident with completion.
    start_run(0, 16, 4, 2, 0);
    k = 0;
    while (n_fs < 2 && k < 200) begin step(1); k++; end
    chk("abt_reach_frame1", n_fs, 2);
    step(5);
    cfg_abort  = 1'b1;
    cmpt_force = 1'b1;
    step(1);
    cfg_abort  = 1'b0;
    cmpt_force = 1'b0;
    chk("abt_add_en", add_en, 0);
    chk("abt_busy", busy, 0);
    chk("abt_idx", frame_idx, 1);
    step(20);
    chk("abt_no_done", n_done, 0);

    // Zero frames means one; zero gap gives a 2-cycle low window.
    start_run(0, 4, 0, 0, 0);
    wait_done(100);
    chk("f0_frames", n_fs, 1);
    chk("f0_done", n_done, 1);
    start_run(0, 4, 2, 0, 0);
    wait_done(100);
    chk("g0_frames", n_fs, 2);
    chk("g0_low_time", low_last, 2);

    // Asynchronous reset mid-capture drops add_en without waiting for a clock.
    start_run(0, 16, 2, 0, 0);
    step(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_add_en", add_en, 0);
    chk("arst_busy", busy, 0);
    step(2);
    rst = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
